// File: rtl/seg7_pkg.sv
// Shared constants and types for the four-digit seven-segment display.
// Segment patterns are active-high, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;
    localparam logic [6:0] SEG_OFF  = 7'h00;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t thous;
        bcd_t huns;
        bcd_t tens;
        bcd_t ones;
    } score_t;

    // Bit i set means digit i (0 = ones) is a leading zero to hide.
    // Invalid codes are nonzero, so they stop the blanking run.
    function automatic logic [NUM_DIGITS-1:0] lz_blank(
        input score_t s,
        input logic   en
    );
        logic [NUM_DIGITS-1:0] b;
        b = '0;
        if (en) begin
            b[3] = (s.thous == 4'd0);
            b[2] = b[3] && (s.huns == 4'd0);
            b[1] = b[2] && (s.tens == 4'd0);
        end
        return b;
    endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high output.
// Codes above 9 render as a dash.
module bcd_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] pat
);

    always_comb begin
        pat = SEG_DASH;
        case (code)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seg7_score_display.sv
// Time-multiplexed four-digit score display driver with per-frame
// snapshot, leading-zero blanking and selectable output polarity.
module seg7_score_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 100000,
    parameter bit ACTIVE_LOW  = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            thous,
    input  logic [3:0]            huns,
    input  logic [3:0]            tens,
    input  logic [3:0]            ones,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int             DW       = $clog2(REFRESH_DIV);
    localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0]  DIV_ONE  = DW'(1);

    localparam logic [NUM_DIGITS-1:0] AN_POL =
        ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
    localparam logic [6:0] SEG_POL = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW;

    logic [DW-1:0]         div_q;
    logic [1:0]            scan_q;
    score_t                snap_q;
    logic                  primed_q;
    logic                  tick;

    score_t                live;
    bcd_t                  digit;
    logic [6:0]            seg_dec;
    logic [NUM_DIGITS-1:0] blank_v;
    logic                  blank;
    logic [NUM_DIGITS-1:0] an_nx;
    logic [6:0]            seg_nx;

    logic [NUM_DIGITS-1:0] an_q;
    logic [6:0]            seg_q;
    logic                  dp_q;

    assign live = '{thous: thous, huns: huns, tens: tens, ones: ones};
    assign tick = primed_q && (div_q == DIV_LAST);

    // Divider is held until primed so the first digit gets a full dwell.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q    <= '0;
            scan_q   <= 2'd0;
            snap_q   <= '0;
            primed_q <= 1'b0;
        end else if (!primed_q) begin
            primed_q <= 1'b1;
            snap_q   <= live;
        end else if (tick) begin
            div_q  <= '0;
            scan_q <= scan_q + 2'd1;
            if (scan_q == 2'd3) begin
                snap_q <= live;
            end
        end else begin
            div_q <= div_q + DIV_ONE;
        end
    end

    always_comb begin
        digit = snap_q.ones;
        unique case (scan_q)
            2'd0: digit = snap_q.ones;
            2'd1: digit = snap_q.tens;
            2'd2: digit = snap_q.huns;
            2'd3: digit = snap_q.thous;
        endcase
    end

    bcd_to_seg7 u_dec (
        .code (digit),
        .pat  (seg_dec)
    );

    always_comb begin
        blank_v = lz_blank(snap_q, blank_lz);
        blank   = blank_v[scan_q];
        an_nx   = '0;
        seg_nx  = SEG_OFF;
        if (!blank) begin
            an_nx  = NUM_DIGITS'(4'b0001 << scan_q);
            seg_nx = seg_dec;
        end
    end

    // Outputs stay dark until the snapshot has been taken once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an_q  <= AN_POL;
            seg_q <= SEG_POL;
            dp_q  <= DP_OFF;
        end else begin
            dp_q <= DP_OFF;
            if (primed_q) begin
                an_q  <= an_nx ^ AN_POL;
                seg_q <= seg_nx ^ SEG_POL;
            end else begin
                an_q  <= AN_POL;
                seg_q <= SEG_POL;
            end
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seg7_score_display.sv
// Bench for seg7_score_display: frame-arithmetic reference model checked
// every cycle, plus directed literal checks.
module tb_seg7_score_display;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] thous = 4'd0;
    logic [3:0] huns = 4'd0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       blank_lz = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;

    int checks = 0;
    int errors = 0;
    bit run = 1'b0;

    seg7_score_display #(
        .REFRESH_DIV (D),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .thous    (thous),
        .huns     (huns),
        .tens     (tens),
        .ones     (ones),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [11:0] act,
                       input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Reference model: edges counted since release; frame/slot from arithmetic.
    function automatic logic [6:0] pat(input logic [3:0] c);
        logic [6:0] tbl [10];
        tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
        if (c > 4'd9) return 7'h40;
        return tbl[c];
    endfunction

    int         k = 0;
    logic [3:0] msnap [4];
    logic [3:0] exp_an = 4'hF;
    logic [6:0] exp_seg = 7'h7F;

    always @(posedge clk or negedge reset) begin : model
        int n;
        int s;
        bit lit;
        if (!reset) begin
            k       <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
        end else begin
            n = k + 1;
            k <= n;
            if ((n - 1) % (4 * D) == 0) begin
                msnap[0] <= ones;
                msnap[1] <= tens;
                msnap[2] <= huns;
                msnap[3] <= thous;
            end
            if (n < 2) begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h7F;
            end else begin
                s = ((n - 2) / D) % 4;
                lit = 1'b1;
                if (blank_lz && s > 0) begin
                    lit = 1'b0;
                    for (int j = s; j < 4; j++)
                        if (msnap[j] != 4'd0) lit = 1'b1;
                end
                exp_an  <= lit ? ~4'(4'b0001 << s) : 4'hF;
                exp_seg <= lit ? ~pat(msnap[s]) : 7'h7F;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("model_an", 12'(an), 12'(exp_an));
            chk("model_seg", 12'(seg), 12'(exp_seg));
            chk("model_dp", 12'(dp), 12'd1);
        end
    end

    task automatic do_reset(input logic [3:0] th, input logic [3:0] hu,
                            input logic [3:0] te, input logic [3:0] on,
                            input logic bl);
        @(negedge clk);
        reset = 1'b0;
        thous = th; huns = hu; tens = te; ones = on;
        blank_lz = bl;
        repeat (2) @(negedge clk);
        chk("rst_an", 12'(an), 12'hF);
        chk("rst_seg", 12'(seg), 12'h7F);
        chk("rst_dp", 12'(dp), 12'd1);
        reset = 1'b1;
    endtask

    task automatic wait_an(input logic [3:0] tgt, input string nm);
        int c = 0;
        while (an !== tgt && c < 200) begin
            @(negedge clk);
            c++;
        end
        if (c >= 200) chk(nm, 12'(an), 12'(tgt));
    endtask

    logic [3:0] t2_an  [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [6:0] t2_seg [4] = '{7'b0011001, 7'b0110000,
                               7'b0100100, 7'b1111001};

    initial begin
        repeat (2) @(negedge clk);
        run = 1'b1;

        // Reset and first frame of zeros with blanking
        do_reset(4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
        @(negedge clk);
        chk("t1_first_edge_an", 12'(an), 12'hF);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i < 4) begin
                chk("t1_ones_an", 12'(an), 12'b1110);
                chk("t1_ones_seg", 12'(seg), 12'b1000000);
            end else begin
                chk("t1_blank_an", 12'(an), 12'b1111);
            end
        end

        // 1,2,3,4 without blanking: full scan order and dwell
        do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t2_an", 12'(an), 12'(t2_an[i / 4]));
            chk("t2_seg", 12'(seg), 12'(t2_seg[i / 4]));
        end

        // 0007 with and without blanking
        do_reset(4'd0, 4'd0, 4'd0, 4'd7, 1'b1);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            chk("t3_hi_an", 12'(an[3:1]), 12'b111);
            if (an == 4'b1110) chk("t3_seg7", 12'(seg), 12'b1111000);
        end
        blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        wait_an(4'b1101, "t3_wait_an1");
        chk("t3_zero_tens", 12'(seg), 12'b1000000);
        wait_an(4'b1011, "t3_wait_an2");
        chk("t3_zero_huns", 12'(seg), 12'b1000000);
        wait_an(4'b0111, "t3_wait_an3");
        chk("t3_zero_thous", 12'(seg), 12'b1000000);

        // Anti-tear: mid-frame change waits for the next frame
        do_reset(4'd0, 4'd0, 4'd0, 4'd5, 1'b0);
        wait_an(4'b1110, "t4_wait0");
        chk("t4_five", 12'(seg), 12'b0010010);
        ones = 4'd6;
        repeat (3) begin
            @(negedge clk);
            chk("t4_still_five", 12'(seg), 12'b0010010);
        end
        wait_an(4'b1101, "t4_wait1");
        wait_an(4'b1110, "t4_wait2");
        chk("t4_six", 12'(seg), 12'b0000010);

        // Invalid code in tens stops blanking and shows a dash
        do_reset(4'd0, 4'd0, 4'hC, 4'd3, 1'b1);
        wait_an(4'b1101, "t5_wait");
        chk("t5_dash", 12'(seg), 12'b0111111);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("t5_upper_blank", 12'(an[3:2]), 12'b11);
        end

        // Asynchronous reset in the middle of a frame
        do_reset(4'd1, 4'd2, 4'd3, 4'd4, 1'b0);
        wait_an(4'b1011, "t6_wait");
        #1 reset = 1'b0;
        #1;
        chk("t6_async_an", 12'(an), 12'hF);
        chk("t6_async_seg", 12'(seg), 12'h7F);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t6_edge1_an", 12'(an), 12'hF);
        @(negedge clk);
        chk("t6_restart_an", 12'(an), 12'b1110);
        chk("t6_restart_seg", 12'(seg), 12'b0011001);
        repeat (20) @(negedge clk);

        run = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

endmodule
